// File: rtl/alu_mc.sv
// Multi-cycle ALU: most opcodes complete in one cycle. MUL (shift-add) and
// DIV (restoring) use a bit-serial datapath that takes WIDTH iterations.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_alu,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   shamp,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             flag_ovf,
  output logic             busy,
  output logic             done
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_mul;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_ph;
  logic [WIDTH-1:0] r_pl;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  logic             w_c;
  logic             w_v;
  logic             w_wr;
  logic             w_calc;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sar;
  logic [31:0]      w_rot_amt;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dsh;
  logic             w_dge;
  logic [WIDTH-1:0] w_ddf;
  logic [WIDTH-1:0] w_ph_n;
  logic [WIDTH-1:0] w_pl_n;

  // One guard bit beside the operand captures the last bit shifted out
  assign w_shl     = {1'b0, in_a} << shamp;
  assign w_shr     = {in_a, 1'b0} >> shamp;
  assign w_sar     = $signed({in_a, 1'b0}) >>> shamp;
  assign w_rot_amt = 32'(shamp) % WIDTH;

  always_comb begin
    w_res  = '0;
    w_hi   = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_wr   = 1'b1;
    w_calc = 1'b0;
    w_ext  = '0;
    case (opcode)
      4'h0, 4'hE: begin
        w_ext = {1'b0, in_a} + {1'b0, in_b}
              + {{WIDTH{1'b0}}, (opcode == 4'hE) & flag_carry};
        w_res = w_ext[M:0];
        w_c   = w_ext[WIDTH];
        w_v   = (in_a[M] == in_b[M]) && (w_res[M] != in_a[M]);
      end
      4'h1, 4'hA: begin
        w_ext = {1'b0, in_a} - {1'b0, in_b};
        w_res = w_ext[M:0];
        w_c   = w_ext[WIDTH];
        w_v   = (in_a[M] != in_b[M]) && (w_res[M] != in_a[M]);
        w_wr  = (opcode == 4'h1);
      end
      4'h2: w_res = in_a & in_b;
      4'h3: w_res = in_a | in_b;
      4'h4: w_res = in_a ^ in_b;
      4'h5: w_res = ~in_a;
      4'h6: begin
        w_res = w_shl[M:0];
        w_c   = w_shl[WIDTH];
      end
      4'h7: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      4'h8: begin
        w_res = w_sar[WIDTH:1];
        w_c   = w_sar[0];
      end
      4'h9: w_res = (in_a << w_rot_amt) | (in_a >> (32'(WIDTH) - w_rot_amt));
      4'hB: begin
        w_ext = {1'b0, in_a} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_ext[M:0];
        w_c   = w_ext[WIDTH];
        w_v   = ~in_a[M] & w_res[M];
      end
      4'hC: w_calc = 1'b1;
      4'hD: begin
        if (in_b == '0) begin
          w_res = '1;
          w_hi  = in_a;
          w_c   = 1'b1;
        end else begin
          w_calc = 1'b1;
        end
      end
      default: w_res = in_b;
    endcase
  end

  // r_ph/r_pl hold product high/low for MUL, remainder/quotient for DIV
  assign w_madd = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_m} : '0);
  assign w_dsh  = {r_ph, r_pl[M]};
  assign w_dge  = w_dsh >= {1'b0, r_m};
  assign w_ddf  = w_dsh[M:0] - r_m;

  always_comb begin
    if (r_mul) begin
      w_ph_n = w_madd[WIDTH:1];
      w_pl_n = {w_madd[0], r_pl[M:1]};
    end else begin
      w_ph_n = w_dge ? w_ddf : w_dsh[M:0];
      w_pl_n = {r_pl[M-1:0], w_dge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mul      <= 1'b0;
      r_m        <= '0;
      r_ph       <= '0;
      r_pl       <= '0;
      alu_out    <= '0;
      alu_out_hi <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
      flag_ovf   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_alu) begin
            if (w_calc) begin
              r_state <= S_CALC;
              busy    <= 1'b1;
              r_cnt   <= '0;
              r_mul   <= (opcode == 4'hC);
              r_m     <= (opcode == 4'hC) ? in_a : in_b;
              r_ph    <= '0;
              r_pl    <= (opcode == 4'hC) ? in_b : in_a;
            end else begin
              done       <= 1'b1;
              flag_zero  <= (w_res == '0);
              flag_carry <= w_c;
              flag_neg   <= w_res[M];
              flag_ovf   <= w_v;
              if (w_wr) begin
                alu_out    <= w_res;
                alu_out_hi <= w_hi;
              end
            end
          end
        end
        S_CALC: begin
          r_ph  <= w_ph_n;
          r_pl  <= w_pl_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            alu_out    <= w_pl_n;
            alu_out_hi <= w_ph_n;
            flag_zero  <= r_mul ? ({w_ph_n, w_pl_n} == '0) : (w_pl_n == '0);
            flag_carry <= r_mul & (w_ph_n != '0);
            flag_neg   <= w_pl_n[M];
            flag_ovf   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed cases plus random
// operations compared against an integer-arithmetic reference model.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_alu;
  logic [3:0] opcode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] shamp;
  logic [7:0] alu_out;
  logic [7:0] alu_out_hi;
  logic       flag_zero;
  logic       flag_carry;
  logic       flag_neg;
  logic       flag_ovf;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int m_out = 0, m_hi = 0, m_z = 0, m_c = 0, m_n = 0, m_v = 0;

  // Shift port widened to 4 bits so amounts beyond WIDTH can be exercised
  alu_mc #(.WIDTH(8), .SHW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_alu (enable_alu),
    .opcode     (opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .shamp      (shamp),
    .alu_out    (alu_out),
    .alu_out_hi (alu_out_hi),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_neg   (flag_neg),
    .flag_ovf   (flag_ovf),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int op, input int a, input int b, input int s);
    int r, hi, c, v, sa, sb, t;
    bit wr;
    r = 0; hi = 0; c = 0; v = 0; wr = 1'b1;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0, 14: begin
        t = a + b + ((op == 14) ? m_c : 0);
        r = t % 256; c = (t > 255) ? 1 : 0;
        t = sa + sb + ((op == 14) ? m_c : 0);
        v = (t > 127 || t < -128) ? 1 : 0;
      end
      1, 10: begin
        r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
        t = sa - sb;
        v = (t > 127 || t < -128) ? 1 : 0;
        wr = (op == 1);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin
        r = (s >= 8) ? 0 : (a << s) % 256;
        c = (s == 0 || s > 8) ? 0 : (a >> (8 - s)) % 2;
      end
      7: begin
        r = (s >= 8) ? 0 : a >> s;
        c = (s == 0 || s > 8) ? 0 : (a >> (s - 1)) % 2;
      end
      8: begin
        if (s >= 8) r = (sa < 0) ? 255 : 0;
        else r = (sa >>> s) & 255;
        if (s == 0) c = 0;
        else if (s > 8) c = (sa < 0) ? 1 : 0;
        else c = (a >> (s - 1)) % 2;
      end
      9: begin
        t = s % 8;
        r = ((a << t) | (a >> (8 - t))) % 256;
      end
      11: begin
        t = a + 1; r = t % 256; c = (t > 255) ? 1 : 0; v = (a == 127) ? 1 : 0;
      end
      12: begin
        t = a * b; r = t % 256; hi = t / 256; c = (hi != 0) ? 1 : 0;
      end
      13: begin
        if (b == 0) begin r = 255; hi = a; c = 1; end
        else begin r = a / b; hi = a % b; end
      end
      default: r = b;
    endcase
    m_z = (op == 12) ? ((a * b == 0) ? 1 : 0) : ((r == 0) ? 1 : 0);
    m_n = (r >= 128) ? 1 : 0;
    m_c = c;
    m_v = v;
    if (wr) begin
      m_out = r;
      m_hi  = hi;
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, " out"}, 32'(alu_out), 32'(m_out));
    chk({tag, " hi"}, 32'(alu_out_hi), 32'(m_hi));
    chk({tag, " flags"}, 32'({flag_zero, flag_carry, flag_neg, flag_ovf}),
        32'({m_z[0], m_c[0], m_n[0], m_v[0]}));
  endtask

  // Present a request for one cycle, then scramble the inputs
  task automatic req(input int op, input int a, input int b, input int s);
    opcode = 4'(op); in_a = 8'(a); in_b = 8'(b); shamp = 4'(s);
    enable_alu = 1'b1;
    @(posedge clk); #1;
    enable_alu = 1'b0;
    opcode = 4'($urandom); in_a = 8'($urandom); in_b = 8'($urandom); shamp = 4'($urandom);
  endtask

  task automatic do_op(input string tag, input int op, input int a, input int b,
                       input int s, input bit poke);
    int cyc;
    bit multi;
    multi = (op == 12) || (op == 13 && b != 0);
    model(op, a, b, s);
    req(op, a, b, s);
    if (!multi) begin
      chk({tag, " done"}, 32'(done), 32'(1));
      chk({tag, " busy"}, 32'(busy), 32'(0));
    end else begin
      cyc = 1;
      while (done !== 1'b1 && cyc <= 20) begin
        chk({tag, " busy"}, 32'(busy), 32'(1));
        if (poke && cyc == 3) begin
          opcode = 4'h0; in_a = 8'd1; in_b = 8'd1; enable_alu = 1'b1;
        end
        @(posedge clk); #1;
        enable_alu = 1'b0;
        cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(9));
      chk({tag, " busy end"}, 32'(busy), 32'(0));
    end
    check_out(tag);
    if (poke) begin
      @(posedge clk); #1;
      chk({tag, " no queued done"}, 32'(done), 32'(0));
      check_out({tag, " hold"});
    end
  endtask

  initial begin
    int op, a, b, s, seen;
    rst_n = 1'b0; enable_alu = 1'b0; opcode = '0; in_a = '0; in_b = '0; shamp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out", 32'({alu_out, alu_out_hi}), 32'(0));
    chk("reset flags", 32'({flag_zero, flag_carry, flag_neg, flag_ovf}), 32'(0));
    chk("reset busy/done", 32'({busy, done}), 32'(0));
    rst_n = 1'b1;

    do_op("add240_30", 0, 240, 30, 0, 1'b0);
    chk("add240_30 const", 32'({alu_out, flag_carry, flag_ovf, flag_zero}), 32'({8'd14, 3'b100}));
    @(posedge clk); #1;
    chk("add done pulse", 32'(done), 32'(0));

    do_op("sub30_30", 1, 30, 30, 0, 1'b0);
    chk("sub const", 32'({alu_out, flag_zero, flag_carry}), 32'({8'd0, 2'b10}));
    do_op("cmp10_20", 10, 10, 20, 0, 1'b0);
    chk("cmp const", 32'({alu_out, flag_carry, flag_neg}), 32'({8'd0, 2'b11}));

    do_op("mul240_30", 12, 240, 30, 0, 1'b1);
    chk("mul const", 32'({alu_out_hi, alu_out, flag_carry}), 32'({16'h1C20, 1'b1}));
    do_op("div240_31", 13, 240, 31, 0, 1'b0);
    chk("div const", 32'({alu_out, alu_out_hi}), 32'({8'd7, 8'd23}));
    do_op("div5_0", 13, 5, 0, 0, 1'b0);
    chk("div0 const", 32'({alu_out, alu_out_hi, flag_carry}), 32'({8'hFF, 8'd5, 1'b1}));

    do_op("shl81_1", 6, 8'h81, 0, 1, 1'b0);
    do_op("sar80_9", 8, 8'h80, 0, 9, 1'b0);
    chk("sar const", 32'(alu_out), 32'(8'hFF));
    do_op("rol81_9", 9, 8'h81, 0, 9, 1'b0);
    chk("rol const", 32'(alu_out), 32'(8'h03));
    do_op("shl_s0", 6, 8'hFF, 0, 0, 1'b0);
    do_op("shr_s8", 7, 8'h80, 0, 8, 1'b0);
    do_op("inc7f", 11, 8'h7F, 0, 0, 1'b0);
    do_op("adc", 14, 8'hFF, 8'h00, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      s  = $urandom_range(0, 15);
      do_op($sformatf("rand%0d op%0h", i, op), op, a, b, s, 1'b0);
    end

    // Reset three cycles into a multiply
    req(12, 200, 200, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("midmul busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midmul reset out", 32'({alu_out, alu_out_hi}), 32'(0));
    chk("midmul reset flags", 32'({flag_zero, flag_carry, flag_neg, flag_ovf}), 32'(0));
    chk("midmul reset busy/done", 32'({busy, done}), 32'(0));
    m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("aborted mul silent", 32'(seen), 32'(0));
    do_op("add1_1", 0, 1, 1, 0, 1'b0);
    chk("add1_1 const", 32'(alu_out), 32'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (legal 4..32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), width of shamp.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable_alu  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port opcode  input  4  operation select.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  operands.
REQ-008 SHALL have port shamp  input  SHW  shift/rotate amount.
REQ-009 SHALL have port alu_out  output  WIDTH  registered result (MUL low half, DIV quotient).
REQ-010 SHALL have port alu_out_hi  output  WIDTH  MUL high half, DIV remainder, else 0.
REQ-011 SHALL have ports flag_zero, flag_carry, flag_neg, flag_ovf  output  1 each  registered status.
REQ-012 SHALL have ports busy, done  output  1 each  multi-cycle in progress; 1-cycle completion pulse.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL, 7 SHR logical, 8 SAR, 9 ROL, A CMP, B INC a, C MUL unsigned, D DIV unsigned, E ADC (a+b+flag_carry), F PASS b.
REQ-014 FSM states SHALL be IDLE and CALC; IDLE->CALC on enable_alu=1 with opcode C/D and in_b!=0 (DIV), CALC->IDLE after WIDTH iterations.
REQ-015 In IDLE, enable_alu=1 SHALL latch opcode, in_a, in_b, shamp and flag_carry; later input changes SHALL not affect the accepted operation.
REQ-016 Single-cycle ops SHALL update outputs and pulse done on the edge that accepts them (done visible one cycle after request).
REQ-017 MUL SHALL be shift-add, DIV restoring, one bit per cycle; busy=1 exactly WIDTH cycles; results and done SHALL appear on the edge ending the last iteration (WIDTH+1 cycles after request).
REQ-018 enable_alu while busy=1 SHALL be ignored, not queued; a new request in the done cycle SHALL be accepted.
REQ-019 Outputs and flags SHALL change only on done; otherwise hold last value.
REQ-020 CMP SHALL update flags as SUB but hold alu_out and alu_out_hi.
REQ-021 flag_carry: ADD/ADC/INC carry-out; SUB/CMP borrow (1 when a<b unsigned); SHL/SHR/SAR last bit shifted out (0 when shamp=0); MUL 1 when high half !=0; DIV 1 on divide-by-zero; 0 for all others.
REQ-022 flag_ovf SHALL be two's-complement overflow for ADD/ADC/SUB/CMP/INC, else 0.
REQ-023 flag_zero SHALL be 1 when the WIDTH-bit result is 0 (MUL: full 2*WIDTH product; CMP: a-b); flag_neg SHALL be result MSB.
REQ-024 Shift amount >= WIDTH SHALL give 0 for SHL/SHR, sign-fill for SAR; ROL SHALL rotate by shamp mod WIDTH.
REQ-025 DIV with in_b=0 SHALL complete single-cycle: alu_out all-ones, alu_out_hi=in_a, flag_carry=1, never entering CALC.
REQ-026 alu_out_hi SHALL be 0 after every op other than MUL/DIV (CMP excepted per REQ-020).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and clear alu_out, alu_out_hi, all flags, busy and done to 0, including mid-CALC; the aborted operation SHALL produce no done.
REQ-028 After rst_n rises, first request SHALL be accepted on the first rising edge with enable_alu=1.

Verification (WIDTH=8)
REQ-029 ADD a=240 b=30 -> next cycle alu_out=14, carry=1, ovf=0, zero=0, done pulse 1 cycle.
REQ-030 SUB a=30 b=30 -> alu_out=0, zero=1, carry=0; then CMP a=10 b=20 -> carry=1, neg=1, alu_out still 0.
REQ-031 MUL a=240 b=30 -> busy 8 cycles, done 9 cycles after request, alu_out=0x20, alu_out_hi=0x1C, carry=1; enable_alu with ADD during busy ignored.
REQ-032 DIV a=240 b=31 -> alu_out=7, alu_out_hi=23 after 9 cycles; DIV a=5 b=0 -> next cycle alu_out=0xFF, alu_out_hi=5, carry=1, busy never 1.
REQ-033 SHL a=0x81 shamp=1 -> 0x02 carry=1; SAR a=0x80 shamp=9 -> 0xFF; ROL a=0x81 shamp=9 -> 0x03.
REQ-034 rst_n low 3 cycles into MUL -> outputs 0 immediately, no done afterward; fresh ADD 1+1 -> alu_out=2.
